arb2to1: RTL and testbench

ARB2TO1 -- requirements
Module: arb2to1

---
 rtl/arb2to1_pkg.sv | 18 +
 rtl/arb2to1_if.sv | 29 ++
 rtl/arb2to1_out_slot.sv | 52 +++++
 rtl/arb2to1.sv | 110 +++++++++++
 tb/tb_arb2to1.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb2to1_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
// The state enum, default sizes and SEL source encoding live here.
package arb2to1_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_BURST = 4;
    localparam int CNT_W     = 4;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

endpackage

// File: rtl/arb2to1_if.sv
// Bundle of the two requester channels and the output channel of arb2to1.
// Handshake: a beat moves on a rising edge where VALID and READY are both 1;
// a source holds VALID and DATA stable until that happens, READY never waits on the same cycle's acceptance.
interface arb2to1_if
    import arb2to1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             A_VALID;
    logic [WIDTH-1:0] A_DATA;
    logic             A_READY;
    logic             B_VALID;
    logic [WIDTH-1:0] B_DATA;
    logic             B_READY;
    logic             OUT_VALID;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_READY;
    logic             SEL;

    modport slave (
        input  A_VALID, A_DATA, B_VALID, B_DATA, OUT_READY,
        output A_READY, B_READY, OUT_VALID, OUT_DATA, SEL
    );

    modport master (
        output A_VALID, A_DATA, B_VALID, B_DATA, OUT_READY,
        input  A_READY, B_READY, OUT_VALID, OUT_DATA, SEL
    );
endinterface

// File: rtl/arb2to1_out_slot.sv
// Single-entry output register: loads an accepted beat with its source tag,
// empties when the consumer takes it and nothing new arrives.
module out_slot
    import arb2to1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_sel,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             sel_q,   sel_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            sel_d   = load_sel;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= SRC_A;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: rtl/arb2to1.sv
// Two-requester burst arbiter: grants A or B for up to BURST beats, alternating
// on contention, and feeds a one-entry output register tagged with the source.
module arb2to1
    import arb2to1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BURST = DEF_BURST
) (
    input  logic             CLK,
    input  logic             RST_N,
    arb2to1_if.slave         bus,
    output state_t           dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             last_q,  last_d;

    logic             out_valid;
    logic             slot_free;
    logic             a_ready, b_ready;
    logic             src_b;
    logic             gnt_valid, oth_valid;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        slot_free = !out_valid || bus.OUT_READY;
        a_ready   = (state_q == GNT_A) && slot_free;
        b_ready   = (state_q == GNT_B) && slot_free;
        src_b     = (state_q == GNT_B);
        gnt_valid = src_b ? bus.B_VALID : bus.A_VALID;
        oth_valid = src_b ? bus.A_VALID : bus.B_VALID;
        accept    = (a_ready && bus.A_VALID) || (b_ready && bus.B_VALID);
        cnt_inc   = cnt_q + CNT_W'(1);
        load_data = src_b ? bus.B_DATA : bus.A_DATA;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On a tie, the side that was not served last goes first.
                if (bus.A_VALID && (!bus.B_VALID || last_q == SRC_B)) begin
                    state_d = GNT_A;
                end else if (bus.B_VALID) begin
                    state_d = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                // A full output slot freezes everything; only free cycles count.
                if (slot_free) begin
                    if (accept) begin
                        last_d = src_b ? SRC_B : SRC_A;
                        cnt_d  = cnt_inc;
                    end
                    if (!gnt_valid || cnt_inc == CNT_W'(BURST)) begin
                        cnt_d = '0;
                        if (oth_valid) begin
                            state_d = src_b ? GNT_A : GNT_B;
                        end else if (!gnt_valid) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= SRC_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    out_slot #(
        .WIDTH (WIDTH)
    ) u_out_slot (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (accept),
        .load_data (load_data),
        .load_sel  (src_b ? SRC_B : SRC_A),
        .out_ready (bus.OUT_READY),
        .out_valid (out_valid),
        .out_data  (bus.OUT_DATA),
        .out_sel   (bus.SEL)
    );

    assign bus.OUT_VALID = out_valid;
    assign bus.A_READY   = a_ready;
    assign bus.B_READY   = b_ready;
    assign dbg_state     = state_q;
    assign dbg_cnt       = cnt_q;

endmodule

// File: tb/tb_arb2to1.sv
// Bench for arb2to1: two instances (BURST=4 and BURST=1) driven by per-instance
// sources, checked every cycle against a grant/beat-budget model and a scoreboard.
module tb_arb2to1;
  import arb2to1_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUTs ----------------
  arb2to1_if #(.WIDTH(W)) bus0();
  arb2to1_if #(.WIDTH(W)) bus1();

  bit             src_v [2][2];
  logic [W-1:0]   src_d [2][2];
  int             rem   [2][2];
  logic           ordy = 1'b1;

  logic           ar [2];
  logic           br [2];
  logic           ov [2];
  logic           sel_w [2];
  logic [W-1:0]   od [2];
  state_t         st [2];
  logic [CNT_W-1:0] cnt_w [2];

  assign bus0.A_VALID = src_v[0][0];
  assign bus0.A_DATA  = src_d[0][0];
  assign bus0.B_VALID = src_v[0][1];
  assign bus0.B_DATA  = src_d[0][1];
  assign bus0.OUT_READY = ordy;
  assign bus1.A_VALID = src_v[1][0];
  assign bus1.A_DATA  = src_d[1][0];
  assign bus1.B_VALID = src_v[1][1];
  assign bus1.B_DATA  = src_d[1][1];
  assign bus1.OUT_READY = ordy;

  assign ar[0] = bus0.A_READY;  assign br[0] = bus0.B_READY;
  assign ov[0] = bus0.OUT_VALID; assign od[0] = bus0.OUT_DATA; assign sel_w[0] = bus0.SEL;
  assign ar[1] = bus1.A_READY;  assign br[1] = bus1.B_READY;
  assign ov[1] = bus1.OUT_VALID; assign od[1] = bus1.OUT_DATA; assign sel_w[1] = bus1.SEL;

  arb2to1 #(.WIDTH(W), .BURST(4)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus0.slave), .dbg_state(st[0]), .dbg_cnt(cnt_w[0])
  );
  arb2to1 #(.WIDTH(W), .BURST(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1.slave), .dbg_state(st[1]), .dbg_cnt(cnt_w[1])
  );

  function automatic int burst_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- source driver ----------------
  int  cfg_prob [2];
  int  cfg_rem  [2];
  bit  cfg_seq;
  int  cfg_ordy;      // 0: always ready, 1: random, 2: stalled
  int  full_id = 0, rem_id = 0, seen_full = 0, seen_rem = 0;
  bit  hs_seen [2][2];

  always @(posedge CLK) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        if (seen_full != full_id) begin
          src_v[k][s] = 1'b0;
          src_d[k][s] = cfg_seq ? ((s == 1) ? 8'h21 : 8'h11) : W'($urandom_range(255));
          rem[k][s] = cfg_rem[s];
        end else if (hs_seen[k][s]) begin
          rem[k][s]--;
          src_v[k][s] = 1'b0;
          src_d[k][s] = cfg_seq ? src_d[k][s] + W'(1) : W'($urandom_range(255));
        end
        if (seen_rem != rem_id) rem[k][s] = cfg_rem[s];
        if (!src_v[k][s] && rem[k][s] > 0 && $urandom_range(99) < cfg_prob[s])
          src_v[k][s] = 1'b1;
      end
    end
    seen_full = full_id;
    seen_rem = rem_id;
    ordy = (cfg_ordy == 0) ? 1'b1 : (cfg_ordy == 2) ? 1'b0 : ($urandom_range(99) < 70);
  end

  // ---------------- model + scoreboard ----------------
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];
  logic [8:0] obs0 [$];
  logic [8:0] obs1 [$];
  int         obs_t0 [$];
  int         obs_t1 [$];
  int         cyc = 0;

  int         m_own [2];   // 0 none, 1 A, 2 B
  int         m_left [2];  // beats still allowed in the current grant
  bit         m_last [2];
  bit         m_ov [2];
  bit         m_os [2];
  logic [W-1:0] m_od [2];
  bit         m_free, m_gv, m_oth, m_ahs, m_bhs;
  logic [8:0] m_front, m_got;
  state_t     m_st;

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST_N) begin
        m_own[k] = 0; m_left[k] = burst_of(k); m_last[k] = 1'b1;
        m_ov[k] = 1'b0; m_os[k] = 1'b0; m_od[k] = '0;
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
        hs_seen[k][0] = 1'b0; hs_seen[k][1] = 1'b0;
        chk($sformatf("rst_ov%0d", k), ov[k], 0);
        chk($sformatf("rst_od%0d", k), od[k], 0);
        chk($sformatf("rst_ar%0d", k), ar[k], 0);
        chk($sformatf("rst_br%0d", k), br[k], 0);
      end else begin
        m_free = !m_ov[k] || ordy;
        m_st = (m_own[k] == 0) ? IDLE : (m_own[k] == 1) ? GNT_A : GNT_B;
        chk($sformatf("a_ready%0d", k), ar[k], (m_own[k] == 1) && m_free);
        chk($sformatf("b_ready%0d", k), br[k], (m_own[k] == 2) && m_free);
        chk($sformatf("out_valid%0d", k), ov[k], m_ov[k]);
        chk($sformatf("out_data%0d", k), od[k], m_od[k]);
        chk($sformatf("sel%0d", k), sel_w[k], m_os[k]);
        chk($sformatf("state%0d", k), st[k], m_st);
        chk($sformatf("count%0d", k), cnt_w[k], (m_own[k] == 0) ? 0 : burst_of(k) - m_left[k]);

        hs_seen[k][0] = src_v[k][0] && ar[k];
        hs_seen[k][1] = src_v[k][1] && br[k];

        if (ov[k] && ordy) begin
          m_got = {sel_w[k], od[k]};
          if (k == 0) begin
            chk("sb_nonempty0", exp_q0.size() > 0, 1);
            if (exp_q0.size() > 0) begin m_front = exp_q0.pop_front(); chk("sb_beat0", m_got, m_front); end
            obs0.push_back(m_got); obs_t0.push_back(cyc);
          end else begin
            chk("sb_nonempty1", exp_q1.size() > 0, 1);
            if (exp_q1.size() > 0) begin m_front = exp_q1.pop_front(); chk("sb_beat1", m_got, m_front); end
            obs1.push_back(m_got); obs_t1.push_back(cyc);
          end
        end

        // advance the model with this cycle's inputs
        m_ahs = (m_own[k] == 1) && m_free && src_v[k][0];
        m_bhs = (m_own[k] == 2) && m_free && src_v[k][1];
        if (m_ahs || m_bhs) begin
          m_ov[k] = 1'b1;
          m_od[k] = m_ahs ? src_d[k][0] : src_d[k][1];
          m_os[k] = m_bhs;
          m_last[k] = m_bhs;
          if (k == 0) exp_q0.push_back({m_bhs, m_od[k]});
          else exp_q1.push_back({m_bhs, m_od[k]});
        end else if (ordy) begin
          m_ov[k] = 1'b0;
        end
        if (m_own[k] == 0) begin
          if (src_v[k][0] && (!src_v[k][1] || m_last[k])) m_own[k] = 1;
          else if (src_v[k][1]) m_own[k] = 2;
          m_left[k] = burst_of(k);
        end else if (m_free) begin
          m_gv  = (m_own[k] == 1) ? src_v[k][0] : src_v[k][1];
          m_oth = (m_own[k] == 1) ? src_v[k][1] : src_v[k][0];
          if (m_gv) m_left[k]--;
          if (!m_gv || m_left[k] == 0) begin
            m_left[k] = burst_of(k);
            if (m_oth) m_own[k] = 3 - m_own[k];
            else if (!m_gv) m_own[k] = 0;
          end
        end
      end
    end
    cyc++;
  end

  function automatic logic [8:0] obs_at(input int k, input int i);
    if (k == 0) return (i < obs0.size()) ? obs0[i] : 9'h1ff;
    return (i < obs1.size()) ? obs1[i] : 9'h1ff;
  endfunction

  function automatic int obs_time(input int k, input int i);
    if (k == 0) return (i < obs_t0.size()) ? obs_t0[i] : -100;
    return (i < obs_t1.size()) ? obs_t1[i] : -100;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit reload);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_ov%0d", k), ov[k], 0);
      chk($sformatf("async_od%0d", k), od[k], 0);
      chk($sformatf("async_sel%0d", k), sel_w[k], 0);
      chk($sformatf("async_ar%0d", k), ar[k], 0);
      chk($sformatf("async_br%0d", k), br[k], 0);
      chk($sformatf("async_state%0d", k), st[k], IDLE);
      chk($sformatf("async_cnt%0d", k), cnt_w[k], 0);
    end
    if (reload) full_id++;
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  task automatic set_cfg(input int pa, input int pb, input int ra, input int rb, input bit seq);
    cfg_prob[0] = pa; cfg_prob[1] = pb;
    cfg_rem[0] = ra;  cfg_rem[1] = rb;
    cfg_seq = seq;
    cfg_ordy = 0;
  endtask

  task automatic check_beats(input string nm, input int k, input int base, input int n,
                             input logic [8:0] exp [16], input bit gapless);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_beat%0d_%0d", nm, k, i), obs_at(k, base + i), exp[i]);
      if (gapless && i > 0)
        chk($sformatf("%s_gap%0d_%0d", nm, k, i), obs_time(k, base + i) - obs_time(k, base + i - 1), 1);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [8:0] e0 [16];
  logic [8:0] e1 [16];
  int b0, b1, na, nb, waited;

  initial begin
    // single source A, data 0x11..0x16
    set_cfg(100, 0, 6, 0, 1'b1);
    b0 = obs0.size(); b1 = obs1.size();
    do_reset(1);
    @(negedge CLK); #1;
    chk("rel_cycle1_a_ready", ar[0], 0);
    @(negedge CLK); #1;
    chk("rel_cycle2_a_ready", ar[0], 1);
    repeat (12) @(negedge CLK);
    #1;
    for (int i = 0; i < 16; i++) e0[i] = {1'b0, 8'h11 + 8'(i)};
    check_beats("single", 0, b0, 6, e0, 1'b1);
    check_beats("single", 1, b1, 6, e0, 1'b1);

    // contention, both always valid
    set_cfg(100, 100, 12, 12, 1'b1);
    b0 = obs0.size(); b1 = obs1.size();
    do_reset(1);
    repeat (30) @(negedge CLK);
    #1;
    na = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (((i / 4) % 2) == 1) begin e0[i] = {1'b1, 8'h21 + 8'(nb)}; nb++; end
      else begin e0[i] = {1'b0, 8'h11 + 8'(na)}; na++; end
    end
    for (int i = 0; i < 8; i++)
      e1[i] = (i % 2 == 1) ? {1'b1, 8'h21 + 8'(i / 2)} : {1'b0, 8'h11 + 8'(i / 2)};
    check_beats("contend", 0, b0, 12, e0, 1'b1);
    check_beats("contend", 1, b1, 8, e1, 1'b1);

    // backpressure for three cycles after two beats
    set_cfg(100, 0, 6, 0, 1'b1);
    b0 = obs0.size();
    do_reset(1);
    repeat (3) @(negedge CLK);
    #1; cfg_ordy = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      chk($sformatf("bp_data_%0d", i), od[0], 8'h12);
      chk($sformatf("bp_valid_%0d", i), ov[0], 1);
      chk($sformatf("bp_sel_%0d", i), sel_w[0], 0);
      chk($sformatf("bp_a_ready_%0d", i), ar[0], 0);
      chk($sformatf("bp_cnt_%0d", i), cnt_w[0], 2);
    end
    cfg_ordy = 0;
    repeat (12) @(negedge CLK);
    #1;
    for (int i = 0; i < 16; i++) e0[i] = {1'b0, 8'h11 + 8'(i)};
    check_beats("bp", 0, b0, 6, e0, 1'b0);

    // bubble: A stops after two beats while B waits, then A returns
    set_cfg(100, 100, 2, 20, 1'b1);
    b0 = obs0.size();
    do_reset(1);
    waited = 0;
    while (obs0.size() - b0 < 3 && waited < 30) begin
      @(negedge CLK); #1;
      waited++;
    end
    chk("bubble_wait", obs0.size() - b0 >= 3, 1);
    cfg_rem[0] = 6;
    rem_id++;
    repeat (20) @(negedge CLK);
    #1;
    e0[0] = {1'b0, 8'h11}; e0[1] = {1'b0, 8'h12};
    for (int i = 0; i < 4; i++) e0[2 + i] = {1'b1, 8'h21 + 8'(i)};
    for (int i = 0; i < 4; i++) e0[6 + i] = {1'b0, 8'h13 + 8'(i)};
    check_beats("bubble", 0, b0, 10, e0, 1'b0);

    // randomized traffic with backpressure and mid-run resets
    set_cfg(60, 60, 1000000, 1000000, 1'b0);
    do_reset(1);
    for (int r = 0; r < 4; r++) begin
      cfg_prob[0] = $urandom_range(100, 20);
      cfg_prob[1] = $urandom_range(100, 20);
      cfg_ordy = 1;
      repeat (400) @(negedge CLK);
      #1;
      if (r < 3) do_reset(1'b0);
    end

    // drain whatever is still pending
    cfg_prob[0] = 0; cfg_prob[1] = 0; cfg_ordy = 0;
    repeat (40) @(negedge CLK);
    #1;
    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
